silencer_settings_loader: RTL and testbench

Fetches silencer configuration from the controller register BRAM on request, validates it, and publishes it as a `settings::silencer_settings_t` with a one-cycle `UPDATE` strobe. It sits between the controller register BRAM (upstream) and the silencer stage, which consumes the struct (downstream). Invalid configurations are rejected, and the previously published values stay in effect.

---
 rtl/silencer_settings_loader.sv | 194 +++++++++++++++++++
 tb/tb_silencer_settings_loader.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/silencer_settings_loader.sv
// Loads silencer settings from the controller register BRAM on a request edge,
// validates them and publishes the result with a one-cycle UPDATE strobe.
package settings;
    typedef struct packed {
        logic       UPDATE;
        logic [7:0] FLAG;
        logic [7:0] UPDATE_RATE_INTENSITY;
        logic [7:0] UPDATE_RATE_PHASE;
        logic [7:0] COMPLETION_STEPS_INTENSITY;
        logic [7:0] COMPLETION_STEPS_PHASE;
    } silencer_settings_t;
endpackage

module silencer_settings_loader #(
    parameter logic [7:0] BASE_ADDR     = 8'h60,
    parameter logic [7:0] DEFAULT_RATE  = 8'd1,
    parameter logic [7:0] DEFAULT_STEPS = 8'd10
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         REQ,
    output logic                         BRAM_EN,
    output logic [7:0]                   BRAM_ADDR,
    input  logic [15:0]                  BRAM_DOUT,
    output settings::silencer_settings_t SILENCER_SETTINGS,
    output logic                         BUSY,
    output logic                         ERR
);
    localparam int unsigned BYTE_W       = 8;
    localparam int unsigned CNT_W        = 3;
    localparam int unsigned NUM_REGS     = 5;
    localparam int unsigned DRAIN_CYCLES = 2;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        CHECK,
        COMMIT
    } state_t;

    state_t                       state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         pend_q, pend_d;
    logic                         busy_q, busy_d;
    logic                         err_q, err_d;
    logic                         en_q, en_d;
    logic [BYTE_W-1:0]            addr_q, addr_d;
    settings::silencer_settings_t set_q, set_d;
    settings::silencer_settings_t set_rst;

    logic                         req_q;
    logic                         req_rise;
    logic [1:0]                   vld_q;
    logic [CNT_W-1:0]             cap_idx_q;
    logic [BYTE_W-1:0]            shadow_q [NUM_REGS];
    logic                         cfg_ok;
    logic                         unused_dout_hi;

    assign unused_dout_hi = ^BRAM_DOUT[15:8];
    assign req_rise       = REQ & ~req_q;
    assign cfg_ok         = (shadow_q[1] != '0) && (shadow_q[2] != '0) &&
                            (shadow_q[3] != '0) && (shadow_q[4] != '0);

    always_comb begin
        set_rst                            = '0;
        set_rst.UPDATE_RATE_INTENSITY      = DEFAULT_RATE;
        set_rst.UPDATE_RATE_PHASE          = DEFAULT_RATE;
        set_rst.COMPLETION_STEPS_INTENSITY = DEFAULT_STEPS;
        set_rst.COMPLETION_STEPS_PHASE     = DEFAULT_STEPS;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        busy_d     = busy_q;
        err_d      = err_q;
        en_d       = 1'b0;
        addr_d     = BASE_ADDR;
        set_d      = set_q;
        set_d.UPDATE = 1'b0;

        if (req_rise && busy_q) begin
            pend_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (req_rise || pend_q) begin
                    state_d = ISSUE;
                    err_d   = 1'b0;
                    pend_d  = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    en_d    = 1'b1;
                    addr_d  = BASE_ADDR;
                end
            end
            ISSUE: begin
                if (cnt_q == CNT_W'(NUM_REGS - 1)) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    en_d   = 1'b1;
                    addr_d = addr_q + BYTE_W'(1);
                end
            end
            DRAIN: begin
                if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
                    state_d = CHECK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CHECK: begin
                // Results land at the CHECK->COMMIT edge so they are visible during COMMIT
                state_d = COMMIT;
                if (cfg_ok) begin
                    set_d.UPDATE                     = 1'b1;
                    set_d.FLAG                       = shadow_q[0];
                    set_d.UPDATE_RATE_INTENSITY      = shadow_q[1];
                    set_d.UPDATE_RATE_PHASE          = shadow_q[2];
                    set_d.COMPLETION_STEPS_INTENSITY = shadow_q[3];
                    set_d.COMPLETION_STEPS_PHASE     = shadow_q[4];
                end
            end
            COMMIT: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                if (!set_q.UPDATE) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            en_q    <= 1'b0;
            addr_q  <= BASE_ADDR;
            set_q   <= set_rst;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            en_q    <= en_d;
            addr_q  <= addr_d;
            set_q   <= set_d;
            req_q   <= REQ;
        end
    end

    // Read-return tracking: data is valid two cycles after each enabled address
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vld_q     <= '0;
            cap_idx_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            vld_q <= {vld_q[0], en_q};
            if (state_q == IDLE) begin
                cap_idx_q <= '0;
            end else if (vld_q[1] && (cap_idx_q < CNT_W'(NUM_REGS))) begin
                shadow_q[cap_idx_q] <= BRAM_DOUT[BYTE_W-1:0];
                cap_idx_q           <= cap_idx_q + CNT_W'(1);
            end
        end
    end

    assign BRAM_EN           = en_q;
    assign BRAM_ADDR         = addr_q;
    assign SILENCER_SETTINGS = set_q;
    assign BUSY              = busy_q;
    assign ERR               = err_q;

endmodule

// File: tb/tb_silencer_settings_loader.sv
// Directed bench for silencer_settings_loader with a two-cycle-latency BRAM model.
module tb_silencer_settings_loader;
    logic                         clk;
    logic                         rst_n;
    logic                         req;
    logic                         bram_en;
    logic [7:0]                   bram_addr;
    logic [15:0]                  bram_dout;
    settings::silencer_settings_t set_out;
    logic                         busy;
    logic                         err;

    logic                         req_fe;
    logic                         bram_en_fe;
    logic [7:0]                   bram_addr_fe;
    logic [15:0]                  bram_dout_fe;
    settings::silencer_settings_t set_fe;
    logic                         busy_fe;
    logic                         err_fe;

    logic [15:0] mem [256];
    logic [15:0] pipe1;

    int checks;
    int errors;

    logic [31:0] upd_mask, busy_mask, en_mask, err_mask;
    logic [63:0] set9;

    localparam logic [63:0] DEF_SET = 64'({1'b0, 8'd0, 8'd1, 8'd1, 8'd10, 8'd10});

    silencer_settings_loader dut (
        .CLK(clk), .RST_N(rst_n), .REQ(req),
        .BRAM_EN(bram_en), .BRAM_ADDR(bram_addr), .BRAM_DOUT(bram_dout),
        .SILENCER_SETTINGS(set_out), .BUSY(busy), .ERR(err)
    );

    silencer_settings_loader #(.BASE_ADDR(8'hFE)) dut_fe (
        .CLK(clk), .RST_N(rst_n), .REQ(req_fe),
        .BRAM_EN(bram_en_fe), .BRAM_ADDR(bram_addr_fe), .BRAM_DOUT(bram_dout_fe),
        .SILENCER_SETTINGS(set_fe), .BUSY(busy_fe), .ERR(err_fe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (bram_en) pipe1 <= mem[bram_addr];
        bram_dout <= pipe1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive req per cycle from a pattern (bit c = cycle c) and record outputs per cycle
    task automatic watch(input logic [31:0] req_pat, input int ncyc);
        upd_mask  = '0;
        busy_mask = '0;
        en_mask   = '0;
        err_mask  = '0;
        set9      = '0;
        for (int c = 0; c <= ncyc; c++) begin
            req          = req_pat[c];
            upd_mask[c]  = set_out.UPDATE;
            busy_mask[c] = busy;
            en_mask[c]   = bram_en;
            err_mask[c]  = err;
            if (c == 9) set9 = 64'(set_out);
            step();
        end
        req = 1'b0;
        step();
        step();
    endtask

    task automatic load_mem(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                            input logic [15:0] w3, input logic [15:0] w4);
        mem[8'h60] = w0;
        mem[8'h61] = w1;
        mem[8'h62] = w2;
        mem[8'h63] = w3;
        mem[8'h64] = w4;
    endtask

    initial begin
        logic [39:0] addr_seq;
        int          upd_seen;
        int          busy_seen;
        checks       = 0;
        errors       = 0;
        req          = 1'b0;
        req_fe       = 1'b0;
        bram_dout_fe = 16'h0;
        pipe1        = 16'h0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        rst_n = 1'b0;
        step();
        step();
        check("rst_settings", 64'(set_out), DEF_SET);
        check("rst_busy", 64'(busy), 0);
        check("rst_err", 64'(err), 0);
        check("rst_en", 64'(bram_en), 0);
        check("rst_addr", 64'(bram_addr), 64'h60);
        rst_n = 1'b1;
        step();
        step();

        // Step count low bytes are zero: rejected, defaults held
        load_mem(16'h0001, 16'h0010, 16'h0020, 16'h0100, 16'h0200);
        watch(32'h1, 12);
        check("inv_update", 64'(upd_mask), 0);
        check("inv_err", 64'(err_mask), 64'h1C00);
        check("inv_busy", 64'(busy_mask), 64'h3FE);
        check("inv_en", 64'(en_mask), 64'h3E);
        check("inv_hold", 64'(set_out), DEF_SET);

        // Valid load; ERR left over from the reject clears at cycle 1
        load_mem(16'h0003, 16'h0004, 16'h0005, 16'h00FA, 16'h0080);
        watch(32'h1, 12);
        check("ok_update", 64'(upd_mask), 64'h200);
        check("ok_set9", set9, 64'({1'b1, 8'd3, 8'd4, 8'd5, 8'd250, 8'd128}));
        check("ok_busy", 64'(busy_mask), 64'h3FE);
        check("ok_err", 64'(err_mask), 64'h1);
        check("ok_final", 64'(set_out), 64'({1'b0, 8'd3, 8'd4, 8'd5, 8'd250, 8'd128}));

        // Edges at cycles 4 and 6 while busy merge into one pending load
        watch(32'h51, 30);
        check("pend_en", 64'(en_mask), 64'hF83E);
        check("pend_update", 64'(upd_mask), 64'h80200);
        check("pend_busy", 64'(busy_mask), 64'hFFBFE);

        // Zero update rate: rejected, prior values kept
        mem[8'h61] = 16'h0000;
        watch(32'h1, 12);
        check("rate0_update", 64'(upd_mask), 0);
        check("rate0_err", 64'(err_mask), 64'h1C00);
        check("rate0_hold", 64'(set_out), 64'({1'b0, 8'd3, 8'd4, 8'd5, 8'd250, 8'd128}));

        load_mem(16'hAB07, 16'hFF04, 16'h0005, 16'h00FA, 16'h0080);
        watch(32'h1, 12);
        check("rec_err", 64'(err_mask), 64'h1);
        check("rec_update", 64'(upd_mask), 64'h200);
        check("rec_set9", set9, 64'({1'b1, 8'd7, 8'd4, 8'd5, 8'd250, 8'd128}));

        // Reset asserted at cycle 6 of a load
        load_mem(16'h0009, 16'h0002, 16'h0002, 16'h0003, 16'h0003);
        req = 1'b1;
        step();
        req = 1'b0;
        for (int c = 1; c < 6; c++) step();
        rst_n = 1'b0;
        #1;
        check("abort_settings", 64'(set_out), DEF_SET);
        check("abort_busy", 64'(busy), 0);
        check("abort_en", 64'(bram_en), 0);
        check("abort_addr", 64'(bram_addr), 64'h60);
        step();
        rst_n = 1'b1;
        upd_seen  = 0;
        busy_seen = 0;
        for (int c = 0; c < 15; c++) begin
            step();
            if (set_out.UPDATE) upd_seen++;
            if (busy) busy_seen++;
        end
        check("abort_no_update", 64'(upd_seen), 0);
        check("abort_no_busy", 64'(busy_seen), 0);

        // Address wrap on the FE-based instance
        addr_seq = '0;
        req_fe = 1'b1;
        step();
        req_fe = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (bram_en_fe) addr_seq = {addr_seq[31:0], bram_addr_fe};
            step();
        end
        check("wrap_addr", 64'(addr_seq), 64'hFEFF000102);
        check("wrap_en_off", 64'(bram_en_fe), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
